// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings, host FSM states and width for the ALU host sequencer
package alu_pkg;

    localparam int W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_GAP,
        ST_LD0,
        ST_LD1,
        ST_LD2,
        ST_WAIT,
        ST_ALU_CLR,
        ST_RESP
    } host_state_e;

    function automatic logic op_is_addsub(alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_host_seq_if.sv
// rtl/alu_host_seq_if.sv - request/response handshakes and ALU bus of the host sequencer
interface alu_host_seq_if #(parameter int W = alu_pkg::W);

    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_w0;
    logic [W-1:0] req_w1;
    logic [W-1:0] req_w2;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_hi;
    logic [W-1:0] rsp_lo;
    logic         rsp_err;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_inbus;
    logic         alu_begin;
    logic         alu_rst;
    logic [W-1:0] alu_outbus;
    logic         alu_c7;
    logic         alu_c8;

    // slave is the sequencer itself; master is the datapath master plus the ALU instance
    modport slave (
        input  req_valid, req_op, req_w0, req_w1, req_w2, rsp_ready,
        input  alu_outbus, alu_c7, alu_c8,
        output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err,
        output alu_op, alu_inbus, alu_begin, alu_rst
    );

    modport master (
        output req_valid, req_op, req_w0, req_w1, req_w2, rsp_ready,
        output alu_outbus, alu_c7, alu_c8,
        input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err,
        input  alu_op, alu_inbus, alu_begin, alu_rst
    );

endinterface

// File: rtl/alu_host_resp.sv
// rtl/alu_host_resp.sv - result capture registers with op-dependent hi/lo mapping
module alu_host_resp
    import alu_pkg::*;
#(
    parameter int W = alu_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         cap_a,
    input  logic         cap_q,
    input  logic         abort,
    input  alu_op_e      op,
    input  logic [W-1:0] outbus,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         err
);

    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    logic         err_q, err_d;

    // add/sub leave their result in A, so A lands in lo and hi stays zero
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        err_d = err_q;
        if (clr || abort) begin
            hi_d  = '0;
            lo_d  = '0;
            err_d = abort;
        end else begin
            if (cap_a) begin
                if (op_is_addsub(op)) lo_d = outbus;
                else                  hi_d = outbus;
            end
            if (cap_q && !op_is_addsub(op)) lo_d = outbus;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            err_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            err_q <= err_d;
        end
    end

    assign hi  = hi_q;
    assign lo  = lo_q;
    assign err = err_q;

endmodule

// File: rtl/alu_host_seq.sv
// rtl/alu_host_seq.sv - host sequencer that loads operands onto the shared-bus ALU and returns results
module alu_host_seq
    import alu_pkg::*;
#(
    parameter int W           = alu_pkg::W,
    parameter int BGN_TO_W0   = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic           CLK,
    input  logic           RST_N,
    alu_host_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    host_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    alu_op_e      op_q, op_d;
    logic [W-1:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
    logic [W-1:0] inbus_q, inbus_d;
    logic         req_ready_q, req_ready_d;
    logic         begin_q, begin_d;
    logic         alu_rst_q, alu_rst_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         clr, cap_a, cap_q, abort;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        clr     = 1'b0;
        cap_a   = 1'b0;
        cap_q   = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            ST_IDLE: if (bus.req_valid && req_ready_q) begin
                op_d    = alu_op_e'(bus.req_op);
                w0_d    = bus.req_w0;
                w1_d    = bus.req_w1;
                w2_d    = bus.req_w2;
                clr     = 1'b1;
                state_d = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = (BGN_TO_W0 > 1) ? ST_GAP : ST_LD0;
            end
            ST_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BGN_TO_W0 - 2)) state_d = ST_LD0;
            end
            ST_LD0: state_d = ST_LD1;
            ST_LD1: state_d = ST_LD2;
            ST_LD2: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            // c8 wins over a timeout landing in the same cycle
            ST_WAIT: begin
                cap_a = bus.alu_c7;
                if (bus.alu_c8) begin
                    cap_q   = 1'b1;
                    state_d = ST_ALU_CLR;
                end else if (CNT_W'(cnt_q + 1'b1) == CNT_W'(TIMEOUT_CYC)) begin
                    abort   = 1'b1;
                    state_d = ST_ALU_CLR;
                end
                if (cnt_q != CNT_W'(TIMEOUT_CYC)) cnt_d = cnt_q + 1'b1;
            end
            ST_ALU_CLR: state_d = ST_RESP;
            ST_RESP: if (rsp_valid_q && bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        begin_d     = (state_d == ST_START);
        alu_rst_d   = (state_d == ST_ALU_CLR);
        rsp_valid_d = (state_d == ST_RESP);
        unique case (state_d)
            ST_LD0:  inbus_d = (op_q == OP_MUL) ? '0 : w0_q;
            ST_LD1:  inbus_d = op_is_addsub(op_q) ? '0 : w1_q;
            ST_LD2:  inbus_d = w2_q;
            default: inbus_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_ADD;
            w0_q        <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
            inbus_q     <= '0;
            req_ready_q <= 1'b0;
            begin_q     <= 1'b0;
            alu_rst_q   <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            inbus_q     <= inbus_d;
            req_ready_q <= req_ready_d;
            begin_q     <= begin_d;
            alu_rst_q   <= alu_rst_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    alu_host_resp #(.W(W)) u_resp (
        .clk    (CLK),
        .rst_n  (RST_N),
        .clr    (clr),
        .cap_a  (cap_a),
        .cap_q  (cap_q),
        .abort  (abort),
        .op     (op_q),
        .outbus (bus.alu_outbus),
        .hi     (bus.rsp_hi),
        .lo     (bus.rsp_lo),
        .err    (bus.rsp_err)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_inbus = inbus_q;
    assign bus.alu_begin = begin_q;
    assign bus.alu_rst   = alu_rst_q;

endmodule
